// File: rtl/config_serial_loader.sv
// Serial-to-parallel configuration loader: deserialises address+data frames into a one-hot
// load strobe and shared data bus for the config-cell bank. Optional macro: CFG_PARITY_EN.
module config_serial_loader #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NCELLS     = 12
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_frame_start,
  input  logic              i_sdi,
  input  logic              i_sdi_valid,
  input  logic              i_err_clear,
  output logic [7:0]        o_dout,
  output logic [NCELLS-1:0] o_load,
  output logic              o_busy,
  output logic              o_err_addr,
  output logic              o_err_abort,
  output logic [7:0]        o_load_count
`ifdef CFG_PARITY_EN
  ,
  output logic              o_err_parity
`endif
);

`ifdef CFG_PARITY_EN
  localparam int unsigned ParBits = 1;
`else
  localparam int unsigned ParBits = 0;
`endif
  localparam int unsigned FLen = ADDR_WIDTH + 8 + ParBits;
  localparam int unsigned CntW = $clog2(FLen + 1);
  localparam logic [ADDR_WIDTH:0] NCellsW = (ADDR_WIDTH + 1)'(NCELLS);

  typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

  state_e              r_state, w_state_next;
  logic [FLen-2:0]     r_shift, w_shift_next;
  logic [CntW-1:0]     r_bit_cnt, w_bit_cnt_next;
  logic [7:0]          r_dout;
  logic [NCELLS-1:0]   r_load;
  logic [7:0]          r_load_count;
  logic                r_err_addr;
  logic                r_err_abort;

  logic [FLen-1:0]       w_frame;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_data;
  logic                  w_last_bit;
  logic                  w_addr_ok;
  logic                  w_par_ok;
  logic                  w_do_load;
  logic                  w_set_addr;
  logic                  w_set_abort;
  logic [NCELLS-1:0]     w_onehot;

  // The final bit is decoded straight off the input so the strobe lands one cycle later.
  assign w_frame     = {r_shift, i_sdi};
  assign w_addr      = w_frame[FLen-1 -: ADDR_WIDTH];
  assign w_data      = w_frame[ParBits +: 8];
  assign w_last_bit  = (r_state == StShift) && !i_frame_start && i_sdi_valid &&
                       (r_bit_cnt == CntW'(FLen - 1));
  assign w_addr_ok   = ({1'b0, w_addr} < NCellsW);
`ifdef CFG_PARITY_EN
  assign w_par_ok    = ~(^w_frame);
`else
  assign w_par_ok    = 1'b1;
`endif
  assign w_do_load   = w_last_bit && w_addr_ok && w_par_ok;
  assign w_set_addr  = w_last_bit && !w_addr_ok;
  assign w_set_abort = (r_state == StShift) && i_frame_start;

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < int'(NCELLS); i++) begin
      w_onehot[i] = (w_addr == ADDR_WIDTH'(i));
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    unique case (r_state)
      StIdle: begin
        if (i_frame_start) begin
          w_state_next   = StShift;
          w_shift_next   = '0;
          w_bit_cnt_next = '0;
        end
      end
      StShift: begin
        if (i_frame_start) begin
          w_shift_next   = '0;
          w_bit_cnt_next = '0;
        end else if (i_sdi_valid) begin
          if (w_last_bit) begin
            w_state_next   = StLoad;
            w_shift_next   = '0;
            w_bit_cnt_next = '0;
          end else begin
            w_shift_next   = {r_shift[FLen-3:0], i_sdi};
            w_bit_cnt_next = r_bit_cnt + CntW'(1);
          end
        end
      end
      StLoad: begin
        w_state_next = i_frame_start ? StShift : StIdle;
        w_shift_next   = '0;
        w_bit_cnt_next = '0;
      end
      default: begin
        w_state_next   = StIdle;
        w_shift_next   = '0;
        w_bit_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_dout       <= '0;
      r_load       <= '0;
      r_load_count <= '0;
    end else begin
      r_load <= w_do_load ? w_onehot : '0;
      if (w_do_load) begin
        r_dout       <= w_data;
        r_load_count <= r_load_count + 8'd1;
      end
    end
  end

  // Sticky flags: a set event in the same cycle overrides the clear.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_err_addr  <= 1'b0;
      r_err_abort <= 1'b0;
    end else begin
      if (w_set_addr)       r_err_addr <= 1'b1;
      else if (i_err_clear) r_err_addr <= 1'b0;
      if (w_set_abort)      r_err_abort <= 1'b1;
      else if (i_err_clear) r_err_abort <= 1'b0;
    end
  end

`ifdef CFG_PARITY_EN
  logic r_err_parity;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_err_parity <= 1'b0;
    end else if (w_last_bit && !w_par_ok) begin
      r_err_parity <= 1'b1;
    end else if (i_err_clear) begin
      r_err_parity <= 1'b0;
    end
  end

  assign o_err_parity = r_err_parity;
`endif

  assign o_dout       = r_dout;
  assign o_load       = r_load;
  assign o_busy       = (r_state != StIdle);
  assign o_err_addr   = r_err_addr;
  assign o_err_abort  = r_err_abort;
  assign o_load_count = r_load_count;

endmodule

// File: tb/tb_config_serial_loader.sv
// Directed bench for config_serial_loader; frame-level tests with hand-computed expectations.
// Optional macro: CFG_PARITY_EN (adds parity-bit frames and the parity error checks).
module tb_config_serial_loader;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_frame_start = 1'b0;
  logic        i_sdi = 1'b0;
  logic        i_sdi_valid = 1'b0;
  logic        i_err_clear = 1'b0;
  logic [7:0]  o_dout;
  logic [11:0] o_load;
  logic        o_busy;
  logic        o_err_addr;
  logic        o_err_abort;
  logic [7:0]  o_load_count;
`ifdef CFG_PARITY_EN
  logic        o_err_parity;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  config_serial_loader #(
    .ADDR_WIDTH (4),
    .NCELLS     (12)
  ) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_frame_start (i_frame_start),
    .i_sdi         (i_sdi),
    .i_sdi_valid   (i_sdi_valid),
    .i_err_clear   (i_err_clear),
    .o_dout        (o_dout),
    .o_load        (o_load),
    .o_busy        (o_busy),
    .o_err_addr    (o_err_addr),
    .o_err_abort   (o_err_abort),
    .o_load_count  (o_load_count)
`ifdef CFG_PARITY_EN
    ,
    .o_err_parity  (o_err_parity)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // frameStart cycle also drives a valid '1' bit, which must be ignored.
  task automatic send_frame(input logic [3:0] a, input logic [7:0] d, input bit stall,
                            input bit par_flip);
    logic [12:0] f;
    int          flen;
`ifdef CFG_PARITY_EN
    flen = 13;
    f    = {a, d, (^{a, d}) ^ par_flip};
`else
    flen = 12;
    f    = {1'b0, a, d};
    if (par_flip) flen = 12;
`endif
    i_frame_start = 1'b1;
    i_sdi_valid   = 1'b1;
    i_sdi         = 1'b1;
    tick();
    i_frame_start = 1'b0;
    for (int i = flen - 1; i >= 0; i--) begin
      if (stall) begin
        i_sdi_valid = 1'b0;
        i_sdi       = ~f[i];
        tick();
        if (i == 5) chk("busy_in_stall", 32'(o_busy), 32'd1);
      end
      i_sdi_valid = 1'b1;
      i_sdi       = f[i];
      tick();
      if (i == 1) chk("no_load_before_last", 32'(o_load), 32'd0);
    end
    i_sdi_valid = 1'b0;
    i_sdi       = 1'b0;
  endtask

  initial begin
    // 1: reset values
    tick();
    tick();
    chk("rst_dout", 32'(o_dout), 32'd0);
    chk("rst_load", 32'(o_load), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_err_addr", 32'(o_err_addr), 32'd0);
    chk("rst_err_abort", 32'(o_err_abort), 32'd0);
    chk("rst_count", 32'(o_load_count), 32'd0);
    i_rstn = 1'b1;
    tick();

    // 2: addr 3, data A5, no stalls
    send_frame(4'd3, 8'hA5, 1'b0, 1'b0);
    chk("f2_load", 32'(o_load), 32'h008);
    chk("f2_dout", 32'(o_dout), 32'hA5);
    chk("f2_count", 32'(o_load_count), 32'd1);
    chk("f2_busy_load", 32'(o_busy), 32'd1);
    tick();
    chk("f2_load_one_cycle", 32'(o_load), 32'd0);
    chk("f2_idle_busy", 32'(o_busy), 32'd0);
    chk("f2_dout_hold", 32'(o_dout), 32'hA5);

    // 3: same frame with alternate stall cycles
    send_frame(4'd3, 8'hA5, 1'b1, 1'b0);
    chk("f3_load", 32'(o_load), 32'h008);
    chk("f3_dout", 32'(o_dout), 32'hA5);
    chk("f3_count", 32'(o_load_count), 32'd2);
    tick();
    chk("f3_load_clr", 32'(o_load), 32'd0);

    // 4: out-of-range address
    send_frame(4'd13, 8'hFF, 1'b0, 1'b0);
    chk("f4_load", 32'(o_load), 32'd0);
    chk("f4_dout", 32'(o_dout), 32'hA5);
    chk("f4_err_addr", 32'(o_err_addr), 32'd1);
    chk("f4_count", 32'(o_load_count), 32'd2);
    tick();
    chk("f4_err_sticky", 32'(o_err_addr), 32'd1);
    i_err_clear = 1'b1;
    tick();
    i_err_clear = 1'b0;
    chk("f4_err_cleared", 32'(o_err_addr), 32'd0);

    // errClear held across a bad-address load: set wins
    i_err_clear = 1'b1;
    send_frame(4'd15, 8'h12, 1'b0, 1'b0);
    chk("set_beats_clear", 32'(o_err_addr), 32'd1);
    tick();
    chk("clear_after_set", 32'(o_err_addr), 32'd0);
    i_err_clear = 1'b0;

    // 5: abort after 6 bits, then addr 0 data 3C
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_sdi_valid = 1'b1;
      i_sdi       = 1'b1;
      tick();
    end
    chk("f5_no_abort_yet", 32'(o_err_abort), 32'd0);
    send_frame(4'd0, 8'h3C, 1'b0, 1'b0);
    chk("f5_err_abort", 32'(o_err_abort), 32'd1);
    chk("f5_load", 32'(o_load), 32'h001);
    chk("f5_dout", 32'(o_dout), 32'h3C);
    chk("f5_count", 32'(o_load_count), 32'd3);
    tick();

    // reset mid-frame
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_sdi_valid = 1'b1;
      i_sdi       = i[0];
      tick();
    end
    i_rstn = 1'b0;
    #2;
    chk("mrst_dout", 32'(o_dout), 32'd0);
    chk("mrst_load", 32'(o_load), 32'd0);
    chk("mrst_busy", 32'(o_busy), 32'd0);
    chk("mrst_errs", 32'({o_err_addr, o_err_abort}), 32'd0);
    chk("mrst_count", 32'(o_load_count), 32'd0);
    tick();
    i_rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_sdi_valid = 1'b1;
      i_sdi       = 1'b1;
      tick();
      if (i == 7) chk("mrst_no_load", 32'(o_load), 32'd0);
    end
    i_sdi_valid = 1'b0;
    chk("mrst_idle", 32'(o_busy), 32'd0);

    // back-to-back frames (frameStart in LOAD) and load counter wrap
    for (int i = 0; i < 255; i++) begin
      send_frame(4'd5, 8'(i), 1'b0, 1'b0);
    end
    chk("wrap_255", 32'(o_load_count), 32'd255);
    chk("b2b_load", 32'(o_load), 32'h020);
    chk("b2b_no_abort", 32'(o_err_abort), 32'd0);
    send_frame(4'd11, 8'hEE, 1'b0, 1'b0);
    chk("wrap_0", 32'(o_load_count), 32'd0);
    chk("top_cell_load", 32'(o_load), 32'h800);
    chk("top_cell_dout", 32'(o_dout), 32'hEE);
    tick();

`ifdef CFG_PARITY_EN
    // 6: parity
    send_frame(4'd1, 8'h01, 1'b0, 1'b1);
    chk("par_bad_load", 32'(o_load), 32'd0);
    chk("par_bad_err", 32'(o_err_parity), 32'd1);
    chk("par_bad_count", 32'(o_load_count), 32'd0);
    tick();
    send_frame(4'd1, 8'h01, 1'b0, 1'b0);
    chk("par_ok_load", 32'(o_load), 32'h002);
    chk("par_ok_dout", 32'(o_dout), 32'h01);
    chk("par_ok_count", 32'(o_load_count), 32'd1);
    i_err_clear = 1'b1;
    tick();
    i_err_clear = 1'b0;
    chk("par_err_cleared", 32'(o_err_parity), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
